pin_config_bank: RTL
====================

PIN_CONFIG_BANK -- requirements
Module: pin_config_bank

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 2: number of configuration fields, at least 1.
REQ-002 SHALL have parameter FIELD_W, default 4: width of each field in bits, at least 1.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles Start must hold a new level before it is accepted, at least 1.
REQ-004 SHALL have port Clk  in  1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port Start  in  1: raw push-button level, already synchronised to Clk.
REQ-007 SHALL have port Unlock  in  1: level; requests reconfiguration.
REQ-008 SHALL have port Switches  in  FIELD_W: value captured into the current field.
REQ-009 SHALL have port Fields_Out  out  NUM_FIELDS*FIELD_W: field i occupies bits [i*FIELD_W +: FIELD_W].
REQ-010 SHALL have port Field_Index  out  max(1,clog2(NUM_FIELDS)): field the next press captures.
REQ-011 SHALL have port Field_Valid  out  NUM_FIELDS: bit i set once field i is captured in the current pass.
REQ-012 SHALL have port Done_Register  out  1: high when all fields are captured and the bank is locked.

Function
REQ-013 Debounce SHALL keep a Start_Stable register and a counter; any cycle Start==Start_Stable clears the counter; a cycle Start!=Start_Stable increments it.
REQ-014 On the edge where the counter is DEBOUNCE_CYCLES-1 and Start!=Start_Stable, the block SHALL load Start_Stable<=Start and clear the counter.
REQ-015 A 0->1 load of Start_Stable SHALL assert a registered Press pulse for exactly one cycle; a 1->0 load SHALL NOT.
REQ-016 FSM states: COLLECT (reset state) and DONE.
REQ-017 COLLECT, Press, no Unlock: the block SHALL capture Switches into field Field_Index and set Field_Valid[Field_Index].
REQ-018 On that capture it SHALL increment Field_Index if below NUM_FIELDS-1; otherwise it SHALL set Field_Index to 0, go to DONE, and set Done_Register.
REQ-019 Latency: if Start is first sampled high at edge k and held, the capture SHALL occur at edge k+DEBOUNCE_CYCLES, and outputs SHALL be visible after it.
REQ-020 DONE: Press SHALL be ignored; Fields_Out, Field_Valid, and Field_Index SHALL hold.
REQ-021 Unlock in either state SHALL set the state to COLLECT, Field_Index to 0, Field_Valid to 0, and Done_Register to 0 at the next edge; Fields_Out SHALL retain prior values until overwritten.
REQ-022 If Press and Unlock coincide, Unlock SHALL win and the press SHALL be discarded.
REQ-023 If NUM_FIELDS=1, Field_Index SHALL be constant 0 and a single press SHALL lead to DONE.
REQ-024 If DEBOUNCE_CYCLES=1, Start_Stable SHALL follow Start with one cycle of delay.
REQ-025 A Start that holds a level for fewer than DEBOUNCE_CYCLES consecutive cycles SHALL produce no Press.

Reset
REQ-026 While Reset is high at an edge, the block SHALL set Fields_Out=0, Field_Valid=0, Field_Index=0, Done_Register=0, state=COLLECT, Start_Stable=0, the counter=0, and Press=0.
REQ-027 Reset SHALL override Unlock and Press; a Start held high through Reset release SHALL count as a new press after DEBOUNCE_CYCLES cycles.

Structure
REQ-028 Package pin_config_pkg SHALL hold the FSM state encoding (COLLECT, DONE) and the default parameter constants.
REQ-029 Sub-module pin_debounce SHALL implement REQ-013 to REQ-015 (params DEBOUNCE_CYCLES; ports Clk, Reset, Start, Start_Stable, Press); pin_config_bank SHALL instantiate it once.

Verification (defaults)
REQ-030 Start high 2 cycles then low -> no Press; Field_Valid=2'b00, Fields_Out=8'h00.
REQ-031 Switches=4'hA, Start high 6 cycles, low 6; Switches=4'h5, repeat -> Fields_Out=8'h5A, Field_Valid=2'b11, Done_Register=1, Field_Index=0; first capture exactly 4 edges after first high sample.
REQ-032 In DONE, Switches=4'hF, press -> Fields_Out stays 8'h5A, Done_Register stays 1.
REQ-033 Unlock 1 cycle in DONE -> Done_Register=0, Field_Valid=0, Fields_Out=8'h5A; press with 4'h3 -> Fields_Out=8'h53, Field_Index=1.
REQ-034 Unlock asserted in the Press cycle during COLLECT at Field_Index=1 -> Field_Index=0, Fields_Out unchanged.
REQ-035 Reset after the first capture, with Start held high through release -> all outputs 0; field 0 captured DEBOUNCE_CYCLES edges after release.

Source files
------------

// File: rtl/pin_config_pkg.sv
// pin_config_pkg: FSM state encoding and default parameters for the pin configuration bank
package pin_config_pkg;
   localparam int DEF_NUM_FIELDS      = 2;
   localparam int DEF_FIELD_W         = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;
endpackage

// File: rtl/pin_debounce.sv
// pin_debounce: accepts a new Start level after it holds for DEBOUNCE_CYCLES cycles, pulses Press on rising acceptance
module pin_debounce
   import pin_config_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   output logic Start_Stable,
   output logic Press
);
   localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [CW-1:0] count;
   // count consecutive cycles Start disagrees with the accepted level; accept on the last one
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Start_Stable <= 1'b0;
         count        <= '0;
         Press        <= 1'b0;
      end else begin
         Press <= 1'b0;
         if (Start == Start_Stable) begin
            count <= '0;
         end else if (count == LAST) begin
            Start_Stable <= Start;
            count        <= '0;
            Press        <= Start;
         end else begin
            count <= count + 1'b1;
         end
      end
   end
endmodule

// File: rtl/pin_config_bank.sv
// pin_config_bank: captures Switches into successive fields on debounced presses, then locks until Unlock
module pin_config_bank
   import pin_config_pkg::*;
#(
   parameter int NUM_FIELDS      = DEF_NUM_FIELDS,
   parameter int FIELD_W         = DEF_FIELD_W,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                                               Clk,
   input  logic                                               Reset,
   input  logic                                               Start,
   input  logic                                               Unlock,
   input  logic [FIELD_W-1:0]                                 Switches,
   output logic [NUM_FIELDS*FIELD_W-1:0]                      Fields_Out,
   output logic [(NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1)-1:0] Field_Index,
   output logic [NUM_FIELDS-1:0]                              Field_Valid,
   output logic                                               Done_Register
);
   localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_FIELDS - 1);
   state_t state;
   logic   press;
   logic   start_stable_unused;
   logic   last;
   pin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .Clk          (Clk),
      .Reset        (Reset),
      .Start        (Start),
      .Start_Stable (start_stable_unused),
      .Press        (press)
   );
   // the final field of a pass wraps the index and locks the bank
   always_comb last = Field_Index == LAST;
   // collect fields on presses; Unlock restarts the pass but keeps captured values
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= COLLECT;
         Fields_Out    <= '0;
         Field_Index   <= '0;
         Field_Valid   <= '0;
         Done_Register <= 1'b0;
      end else if (Unlock) begin
         state         <= COLLECT;
         Field_Index   <= '0;
         Field_Valid   <= '0;
         Done_Register <= 1'b0;
      end else if (state == COLLECT && press) begin
         Fields_Out[Field_Index*FIELD_W +: FIELD_W] <= Switches;
         Field_Valid[Field_Index]                   <= 1'b1;
         Field_Index                                <= last ? '0 : Field_Index + 1'b1;
         state                                      <= last ? DONE : COLLECT;
         Done_Register                              <= last;
      end
   end
endmodule
